sram_responder: RTL

//  Synthesizable model of the async SRAM chip behind sram_controller: the responder on the
//  ram_* pin bus. Samples ce_n/oe_n/we_n/be_n/addr with clk, serves reads after a fixed latency,

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_byte_array.sv | 30 +++
 rtl/sram_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM pin-bus responder.
package sram_pkg;

   localparam int unsigned SRAM_DATA_WIDTH = 32;
   localparam int unsigned SRAM_BE_WIDTH   = 4;

   typedef logic [SRAM_DATA_WIDTH-1:0] Word_t;
   typedef logic [19:0]                Ram_addr_t;

   typedef enum logic [1:0] {
      StIdle,
      StReadWait,
      StReadDrive,
      StWrite
   } SramRespState_t;

   // Active-low pin byte enables to active-high array lane enables.
   function automatic logic [SRAM_BE_WIDTH-1:0] be_n_to_we(input logic [SRAM_BE_WIDTH-1:0] be_n);
      return ~be_n;
   endfunction

endpackage

// File: rtl/sram_byte_array.sv
// Word-organised synchronous RAM: one registered read port, one byte-masked write port.
// Contents are not reset; an aborted access therefore leaves the array untouched.
module sram_byte_array
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 12
) (
   input  logic                     clk,
   input  logic                     rd_en,
   input  logic [ADDR_BITS-1:0]     rd_addr,
   output Word_t                    rd_data,
   input  logic [SRAM_BE_WIDTH-1:0] wr_be,
   input  logic [ADDR_BITS-1:0]     wr_addr,
   input  Word_t                    wr_data
);

   Word_t mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < SRAM_BE_WIDTH; i++) begin
         if (wr_be[i]) begin
            mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sram_responder.sv
// Async SRAM chip model on the ram_* pin bus: sampled pins, fixed read latency, byte-masked
// writes committed on we_n/ce_n release. Optional checker enabled by SRAM_RESP_CHECK_EN.
module sram_responder
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 20,
   parameter int unsigned MEM_ADDR_BITS = 12,
   parameter int unsigned READ_LATENCY  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   inout  wire  [SRAM_DATA_WIDTH-1:0] ram_data,
   input  logic [ADDR_WIDTH-1:0]    ram_addr,
   input  logic [SRAM_BE_WIDTH-1:0] ram_be_n,
   input  logic                     ram_ce_n,
   input  logic                     ram_oe_n,
   input  logic                     ram_we_n,
   output logic                     busy,
   output logic [15:0]              read_count,
   output logic [15:0]              write_count,
   output logic                     proto_err
);

   localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   SramRespState_t state_q, state_d;

   logic                     s_ce_n, s_oe_n, s_we_n;
   logic [SRAM_BE_WIDTH-1:0] s_be_n;
   logic [ADDR_WIDTH-1:0]    s_addr;
   Word_t                    s_data;

   logic [ADDR_WIDTH-1:0]    addr_q;
   logic [SRAM_BE_WIDTH-1:0] be_q;
   Word_t                    wbuf_q;
   logic [LatW-1:0]          lat_q;
   logic [15:0]              read_count_q, write_count_q;

   logic  latch_wr_entry, latch_wr_data, latch_rd, dec_lat, rd_en, commit, inc_rd, drive;
   logic  addr_moved;
   Word_t rd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ce_n <= 1'b1;
         s_oe_n <= 1'b1;
         s_we_n <= 1'b1;
         s_be_n <= '1;
         s_addr <= '0;
         s_data <= '0;
      end else begin
         s_ce_n <= ram_ce_n;
         s_oe_n <= ram_oe_n;
         s_we_n <= ram_we_n;
         s_be_n <= ram_be_n;
         s_addr <= ram_addr;
         s_data <= ram_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign addr_moved = (s_addr != addr_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (!s_ce_n && !s_we_n) begin
               state_d = StWrite;
            end else if (!s_ce_n && !s_oe_n) begin
               state_d = StReadWait;
            end
         end
         StReadWait: begin
            if (s_ce_n || s_oe_n) begin
               state_d = StIdle;
            end else if (lat_q == '0) begin
               state_d = StReadDrive;
            end
         end
         StReadDrive: begin
            if (s_ce_n || s_oe_n) begin
               state_d = StIdle;
            end else if (!s_we_n) begin
               state_d = StWrite;
            end else if (addr_moved) begin
               state_d = StReadWait;
            end
         end
         StWrite: begin
            if (s_we_n || s_ce_n) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      latch_wr_entry = 1'b0;
      latch_wr_data  = 1'b0;
      latch_rd       = 1'b0;
      dec_lat        = 1'b0;
      rd_en          = 1'b0;
      commit         = 1'b0;
      inc_rd         = 1'b0;
      unique case (state_q)
         StIdle: begin
            latch_wr_entry = !s_ce_n && !s_we_n;
            latch_rd       = !s_ce_n && s_we_n && !s_oe_n;
         end
         StReadWait: begin
            dec_lat = !s_ce_n && !s_oe_n && (lat_q != '0);
            rd_en   = !s_ce_n && !s_oe_n && (lat_q == '0);
         end
         StReadDrive: begin
            inc_rd         = s_ce_n || s_oe_n || !s_we_n;
            latch_wr_entry = !s_ce_n && !s_oe_n && !s_we_n;
            latch_rd       = !s_ce_n && !s_oe_n && s_we_n && addr_moved;
         end
         StWrite: begin
            latch_wr_data = !s_we_n && !s_ce_n;
            commit        = s_we_n || s_ce_n;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q        <= '0;
         be_q          <= '1;
         wbuf_q        <= '0;
         lat_q         <= '0;
         read_count_q  <= '0;
         write_count_q <= '0;
      end else begin
         if (latch_wr_entry || latch_rd) begin
            addr_q <= s_addr;
         end
         if (latch_wr_entry || latch_wr_data) begin
            be_q   <= s_be_n;
            wbuf_q <= s_data;
         end
         if (latch_rd) begin
            lat_q <= LatW'(READ_LATENCY - 1);
         end else if (dec_lat) begin
            lat_q <= lat_q - 1'b1;
         end
         if (inc_rd) begin
            read_count_q <= read_count_q + 16'd1;
         end
         if (commit) begin
            write_count_q <= write_count_q + 16'd1;
         end
      end
   end

   sram_byte_array #(
      .ADDR_BITS (MEM_ADDR_BITS)
   ) u_array (
      .clk     (clk),
      .rd_en   (rd_en),
      .rd_addr (addr_q[MEM_ADDR_BITS-1:0]),
      .rd_data (rd_q),
      .wr_be   (commit ? be_n_to_we(be_q) : '0),
      .wr_addr (addr_q[MEM_ADDR_BITS-1:0]),
      .wr_data (wbuf_q)
   );

   // Drive gating uses raw pins so the bus is released in the same cycle oe_n/ce_n rise.
   always_comb begin
      busy  = (state_q != StIdle);
      drive = (state_q == StReadDrive) && !ram_ce_n && !ram_oe_n && ram_we_n;
   end

   assign ram_data    = drive ? rd_q : 'z;
   assign read_count  = read_count_q;
   assign write_count = write_count_q;

`ifdef SRAM_RESP_CHECK_EN
   logic proto_q, proto_hit;

   always_comb begin
      proto_hit = (!s_ce_n && !s_oe_n && !s_we_n) ||
                  ((state_q == StWrite) && !s_we_n && !s_ce_n &&
                   ((s_addr != addr_q) || (s_be_n != be_q)));
`ifndef SYNTHESIS
      // Another agent appears to be driving the bus when a read is launched.
      if ((state_q == StIdle) && !s_ce_n && !s_oe_n && s_we_n &&
          !$isunknown(s_data) && (s_data != '0)) begin
         proto_hit = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         proto_q <= 1'b0;
      end else if (proto_hit) begin
         proto_q <= 1'b1;
      end
   end

   assign proto_err = proto_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule
